// File: rtl/inner_shuffle_ctrl.sv
// Ping-pong tile transposer scheduler for one elasticmem: row-major writes fill a bank,
// column-major read requests drain it, and beats seen on the read-data tap release it.
module inner_shuffle_ctrl #(
    parameter int WIDTH = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int AW    = $clog2(2*ROWS*COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] idat,
    input  logic             ivld,
    output logic             irdy,
    output logic [WIDTH-1:0] wr_data,
    output logic [AW-1:0]    wr_addr,
    output logic             wr_en,
    output logic [AW-1:0]    rd_addr,
    output logic             rd_req_vld,
    input  logic             rd_req_rdy,
    input  logic             mon_vld,
    input  logic             mon_rdy,
    output logic [1:0]       bank_full
);
    localparam int TILE = ROWS*COLS;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [AW-1:0] TILE_A = AW'(TILE);
    localparam logic [AW-1:0] LAST_A = AW'(TILE-1);
    localparam logic [AW-1:0] COLS_A = AW'(COLS);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS-1);
    localparam logic [CW-1:0] C_LAST = CW'(COLS-1);

    typedef enum logic {R_IDLE, R_ISSUE} rstate_t;
    rstate_t state, state_nxt;

    logic          wb, rb, iss_b;
    logic [1:0]    issued;
    logic [AW-1:0] wr_cnt, beat_cnt, col_base;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic          wr_done, beat, rel, fire, last_req, start, done, nb;

    assign irdy       = rst & ~bank_full[wb];
    assign wr_en      = ivld & irdy;
    assign wr_data    = idat;
    assign wr_addr    = (wb ? TILE_A : '0) + wr_cnt;
    assign wr_done    = wr_en && (wr_cnt == LAST_A);
    assign beat       = mon_vld & mon_rdy;
    assign rel        = beat && (beat_cnt == LAST_A);
    assign rd_req_vld = rst && (state == R_ISSUE);
    assign fire       = rd_req_vld & rd_req_rdy;
    assign last_req   = (r == R_LAST) && (c == C_LAST);

    // On the last request of a tile, chain straight into the other bank if it is ready.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done      = 1'b0;
        nb        = (state == R_ISSUE) ? ~iss_b : iss_b;
        case (state)
            R_IDLE: begin
                if (bank_full[iss_b] && !issued[iss_b]) begin
                    state_nxt = R_ISSUE;
                    start     = 1'b1;
                end
            end
            R_ISSUE: begin
                if (fire && last_req) begin
                    done = 1'b1;
                    if (bank_full[~iss_b] && !issued[~iss_b]) start = 1'b1;
                    else state_nxt = R_IDLE;
                end
            end
            default: state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= R_IDLE;
            wb        <= 1'b0;
            rb        <= 1'b0;
            iss_b     <= 1'b0;
            issued    <= 2'b00;
            bank_full <= 2'b00;
            wr_cnt    <= '0;
            beat_cnt  <= '0;
            r         <= '0;
            c         <= '0;
            rd_addr   <= '0;
            col_base  <= '0;
        end else begin
            state <= state_nxt;
            if (wr_en) wr_cnt <= wr_done ? '0 : wr_cnt + AW'(1);
            if (wr_done) wb <= ~wb;
            if (beat) beat_cnt <= rel ? '0 : beat_cnt + AW'(1);
            if (rel) rb <= ~rb;
            if (done) iss_b <= ~iss_b;
            bank_full <= (bank_full | (wr_done ? 2'b01 << wb : 2'b00))
                       & ~(rel ? 2'b01 << rb : 2'b00);
            issued    <= (issued | (done ? 2'b01 << iss_b : 2'b00))
                       & ~(rel ? 2'b01 << rb : 2'b00);
            // Running address: down a column by +COLS, next column restarts from col_base+1.
            if (start) begin
                r        <= '0;
                c        <= '0;
                rd_addr  <= nb ? TILE_A : '0;
                col_base <= nb ? TILE_A : '0;
            end else if (fire) begin
                if (r == R_LAST) begin
                    r        <= '0;
                    c        <= c + CW'(1);
                    rd_addr  <= col_base + AW'(1);
                    col_base <= col_base + AW'(1);
                end else begin
                    r       <= r + RW'(1);
                    rd_addr <= rd_addr + COLS_A;
                end
            end
        end
    end

    // A returning beat must belong to a tile that has been (or is being) issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!beat || issued[rb] || (state == R_ISSUE && iss_b == rb));
            assert (!(wr_en && bank_full[wb]));
        end
    end
endmodule
